// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store path feeds a small FIFO,
// STATUS is read combinationally. Optional even parity via `UART_PARITY_EN.
module mmio_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [9:0]  BASE_ADDR    = 10'h3F0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  address,
    input  logic [31:0] data_in,
    input  logic [3:0]  width,
    input  logic        write_mem,
    output logic [31:0] data_out,
    output logic        tx
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        DEPTH_CNT = 4'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_PARITY_EN
    logic              parity_q, parity_d;
`endif
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        count_q, count_d;
    logic              overflow_q, overflow_d;

    logic txdata_sel, status_sel, full, empty, busy;
    logic push_req, accept, pop, drop, clr_ovf, baud_last;

    logic unused_bits;
    assign unused_bits = ^{address[1:0], data_in[31:8], width[3:1]};

    // Address decode, FIFO handshakes and overflow conditions
    always_comb begin
        txdata_sel = (address[9:2] == BASE_ADDR[9:2]);
        status_sel = (address[9:2] == BASE_ADDR[9:2] + 8'd1);
        full       = (count_q == DEPTH_CNT);
        empty      = (count_q == 4'd0);
        busy       = (state_q != S_IDLE);
        pop        = (state_q == S_IDLE) && !empty;
        push_req   = write_mem && txdata_sel && width[0];
        accept     = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        clr_ovf    = write_mem && status_sel && width[0] && data_in[3];
        baud_last  = (baud_q == BAUD_LAST);
    end

    // Combinational STATUS read; TXDATA and unmapped addresses read zero
    always_comb begin
        data_out = 32'h0;
        if (status_sel) begin
            data_out = {24'h0, count_q, overflow_q, empty, full, busy};
        end
    end

    // FIFO pointers, storage, occupancy and sticky overflow (set beats clear)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            mem_d[wr_ptr_q] = data_in[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + 4'(accept) - 4'(pop);
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Shifter next state; tx is registered alongside the state it belongs to
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
`ifdef UART_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d  = S_START;
                    shift_d  = mem_q[rd_ptr_q];
                    baud_d   = '0;
                    tx_d     = 1'b0;
`ifdef UART_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_last) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers; FIFO storage needs no reset since count gates its use
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h0;
            tx_q       <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
`ifdef UART_PARITY_EN
            parity_q   <= parity_d;
`endif
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
        mem_q <= mem_d;
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: queue-based reference model, frame scoreboard on tx.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [9:0]  BASE  = 10'h3F0;
    localparam logic [9:0]  STAT  = 10'h3F4;
`ifdef UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME_CYC = NBITS * CPB;

    logic        clk;
    logic        reset;
    logic [9:0]  address;
    logic [31:0] data_in;
    logic [3:0]  width;
    logic        write_mem;
    logic [31:0] data_out;
    logic        tx;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    int         frame_left;
    logic       model_ovf;
    logic       mon_en;

    mmio_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .data_in  (data_in),
        .width    (width),
        .write_mem(write_mem),
        .data_out (data_out),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [3:0] cnt;
        cnt = 4'(model_q.size());
        return {24'h0, cnt, model_ovf, (model_q.size() == 0), (model_q.size() == DEPTH),
                (frame_left != 0)};
    endfunction

    function automatic logic [31:0] model_dout(input logic [9:0] a);
        logic [7:0] st_word;
        st_word = BASE[9:2] + 8'd1;
        return (a[9:2] == st_word) ? model_status() : 32'h0;
    endfunction

    task automatic model_reset();
        model_q.delete();
        exp_q.delete();
        frame_left = 0;
        model_ovf  = 1'b0;
    endtask

    // One clock edge of the reference behaviour
    task automatic model_edge(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w,
                              input logic wr);
        logic [7:0] st_word;
        logic sel_tx, sel_st, pop, full, push, clr, drop;
        st_word = BASE[9:2] + 8'd1;
        sel_tx  = (a[9:2] == BASE[9:2]);
        sel_st  = (a[9:2] == st_word);
        pop     = (frame_left == 0) && (model_q.size() > 0);
        full    = (model_q.size() == DEPTH);
        push    = wr && sel_tx && w[0];
        clr     = wr && sel_st && w[0] && d[3];
        drop    = push && full && !pop;
        if (pop) begin
            exp_q.push_back(model_q.pop_front());
            frame_left = FRAME_CYC;
        end else if (frame_left > 0) begin
            frame_left--;
        end
        if (push && !drop) model_q.push_back(d[7:0]);
        if (drop) model_ovf = 1'b1;
        else if (clr) model_ovf = 1'b0;
    endtask

    // Apply one cycle of inputs starting from a falling edge
    task automatic step(input logic [9:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic wr);
        address   = a;
        data_in   = d;
        width     = w;
        write_mem = wr;
        #1;
        check32("data_out", data_out, model_dout(a));
        if (frame_left == 0) check32("tx_idle", 32'(tx), 32'h1);
        if (reset) model_reset();
        else model_edge(a, d, w, wr);
        @(negedge clk);
    endtask

    task automatic peek_status(input string name, input logic [31:0] exp);
        address   = STAT;
        write_mem = 1'b0;
        #1;
        check32(name, data_out, exp);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((frame_left != 0 || model_q.size() != 0) && n < 3000) begin
            step(STAT, 32'h0, 4'h0, 1'b0);
            n++;
        end
        step(STAT, 32'h0, 4'h0, 1'b0);
        check32("drain_bound", 32'(n < 3000), 32'h1);
        check32("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Frame monitor: on each start bit, pops the expected byte and checks every cycle
    initial begin
        logic       last_tx;
        logic [7:0] eb;
        logic [NBITS-1:0] fr;
        logic       bad, aborted;
        last_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                last_tx = 1'b1;
            end else if (last_tx === 1'b1 && tx === 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL frame_start: tx fell with no byte expected at %0t", $time);
                end else begin
                    eb = exp_q.pop_front();
`ifdef UART_PARITY_EN
                    fr = {1'b1, ^eb, eb, 1'b0};
`else
                    fr = {1'b1, eb, 1'b0};
`endif
                    bad     = (frame_left != FRAME_CYC);
                    if (bad) begin
                        miscompares++;
                        $display("FAIL frame_timing: start seen with %0d cycles left, expected %0d",
                                 frame_left, FRAME_CYC);
                    end
                    aborted = 1'b0;
                    for (int b = 0; b < NBITS && !aborted; b++) begin
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (!(b == 0 && c == 0)) @(negedge clk);
                            if (!mon_en) aborted = 1'b1;
                            else if (tx !== fr[b] && !bad) begin
                                bad = 1'b1;
                                miscompares++;
                                $display("FAIL frame_bits: byte 0x%02h slot %0d got tx=%b expected %b",
                                         eb, b, tx, fr[b]);
                            end
                        end
                    end
                end
                last_tx = 1'b1;
            end else begin
                last_tx = tx;
            end
        end
    end

    initial begin
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  w;
        logic        wr;
        logic        stayed_high;

        reset     = 1'b1;
        address   = 10'h0;
        data_in   = 32'h0;
        width     = 4'h0;
        write_mem = 1'b0;
        mon_en    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        peek_status("reset_status", 32'h4);
        check32("reset_tx", 32'(tx), 32'h1);

        // Single byte 0x55
        step(BASE, 32'h55, 4'b0001, 1'b1);
        peek_status("push_count", 32'h10);
        step(STAT, 32'h0, 4'h0, 1'b0);
        peek_status("pop_busy", 32'h5);
        check32("start_bit", 32'(tx), 32'h0);
        drain();

        // Five back-to-back stores, then a dropped sixth
        for (int i = 1; i <= 5; i++) step(BASE, 32'(i), 4'b0001, 1'b1);
        step(BASE, 32'h06, 4'b0001, 1'b1);
        peek_status("overflow_status", 32'h4B);
        step(STAT, 32'h08, 4'b0001, 1'b1);
        peek_status("overflow_clear", 32'h43);
        drain();

        // Upper-lane-only store to TXDATA is ignored
        step(BASE, 32'h0000_AB00, 4'b0010, 1'b1);
        peek_status("lane_ignored", 32'h4);
        check32("lane_tx", 32'(tx), 32'h1);

        // Randomised traffic
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 3))
                0: a = BASE | 10'($urandom_range(0, 3));
                1: a = STAT | 10'($urandom_range(0, 3));
                2: a = BASE | 10'($urandom_range(0, 1));
                default: a = 10'($urandom);
            endcase
            d  = $urandom;
            w  = 4'($urandom_range(0, 15));
            wr = ($urandom_range(0, 3) == 0);
            step(a, d, w, wr);
        end
        drain();

        // Reset in the middle of a frame
        step(BASE, 32'hC3, 4'b0001, 1'b1);
        step(STAT, 32'h0, 4'h0, 1'b0);
        repeat (9) step(STAT, 32'h0, 4'h0, 1'b0);
        mon_en = 1'b0;
        reset  = 1'b1;
        step(STAT, 32'h0, 4'h0, 1'b0);
        reset  = 1'b0;
        peek_status("midframe_reset_status", 32'h4);
        check32("midframe_reset_tx", 32'(tx), 32'h1);
        stayed_high = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step(STAT, 32'h0, 4'h0, 1'b0);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        check32("post_reset_quiet", 32'(stayed_high), 32'h1);
        mon_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the CPU data port, downstream of the core's store path. It decodes the core's data address, byte-lane `width`, and `write_mem` strobe, and queues store bytes in a small FIFO. It serialises them 8N1 on `tx` and returns a combinational status word on loads, so the single-cycle core reads it in the same cycle.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, 4: FIFO entries; power of two, 2..8.
- `BASE_ADDR`, 10'h3F0: byte address of TXDATA, word aligned. STATUS is at `BASE_ADDR+4`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset; sampled on rising edge of `clk`.
- `address`  in  10  CPU data byte address.
- `data_in`  in  32  CPU store data, already lane-shifted by the core.
- `width`  in  4  byte-lane enables; bit n covers `data_in[8n+7:8n]`.
- `write_mem`  in  1  store strobe, valid for one cycle per store.
- `data_out`  out  32  read data; combinational.
- `tx`  out  1  serial line; idles high.

## Operation
- Address decode:
  - TXDATA is selected when `address[9:2] == BASE_ADDR[9:2]`.
  - STATUS is selected when `address[9:2] == BASE_ADDR[9:2]+1`.
  - `address[1:0]` is ignored.
- Push: `write_mem & TXDATA selected & width[0]` enqueues `data_in[7:0]`. Writes to TXDATA with `width[0]=0` have no effect.
- STATUS read value on `data_out`:
  - bit0 busy: shifter not IDLE.
  - bit1 full: count == FIFO_DEPTH.
  - bit2 empty: count == 0.
  - bit3 overflow: sticky.
  - bits[7:4] count.
  - All other bits are 0.
- TXDATA reads return 0. Unselected addresses return 0.
- Overflow:
  - A push while full with no pop in the same cycle is dropped and sets overflow.
  - A push while full with a pop in the same cycle is accepted; count is unchanged.
- A store to STATUS with `width[0]=1` and `data_in[3]=1` clears overflow. If a drop occurs in the same cycle, overflow stays set (set wins).
- Shifter FSM:
  - IDLE: `tx=1`. If the FIFO is non-empty, pop the head into the shift register, go to START.
  - START: `tx=0` for CLKS_PER_BIT cycles, then DATA.
  - DATA: `tx=shift[0]` for CLKS_PER_BIT cycles per bit. Shift right after each bit; after bit 7, go to STOP, or to PARITY when the macro is enabled.
  - PARITY (macro only): `tx` = even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP.
  - STOP: `tx=1` for CLKS_PER_BIT cycles, then IDLE.
- Counters:
  - Baud counter is `$clog2(CLKS_PER_BIT)` bits, counts 0..CLKS_PER_BIT-1, and wraps at every bit boundary.
  - Bit index is 3 bits.
- FIFO read/write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo depth. Count is a separate 4-bit register.

## Timing
- Reset values: `tx=1`, state IDLE, count 0, pointers 0, overflow 0, baud counter 0. `data_out` follows the reset state combinationally (STATUS reads 0x04).
- Push at edge N: count increments and status reflects it after edge N.
- With IDLE and the FIFO empty before edge N:
  - Pop occurs at edge N+1.
  - `tx` falls after edge N+1.
- Frame length: 10×CLKS_PER_BIT cycles, or 11× with parity. IDLE lasts exactly one cycle between back-to-back frames.
- Reset asserted mid-frame: at the next edge, `tx` returns high, the FIFO is flushed, and the frame is abandoned. No partial stop bit is produced.
- `data_out` has zero-cycle latency from `address`.

## Configuration
- `UART_PARITY_EN`:
  - Defined: the PARITY state is compiled in; frames are 8E1 (11 bits).
  - Undefined: PARITY is absent; frames are 8N1 (10 bits).
- The STATUS layout is the same in both builds.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- Reset, then read 0x3F4 -> `data_out`=0x00000004; `tx`=1.
- Store 0x55 to 0x3F0 with width=0001 -> `tx` low for 4 cycles starting after the following edge; then 1,0,1,0,1,0,1,0 at 4 cycles each; then high for 4; STATUS busy=1 throughout the frame.
- Five back-to-back stores 0x01..0x05 with the shifter idle -> first byte popped; bytes 2..5 fill the FIFO; no overflow. A sixth store next cycle -> dropped; STATUS=0x0000004B (count 4, overflow, full, busy).
- Store to 0x3F0 with width=0010 -> count stays 0; `tx` stays 1. Store 0x08 to 0x3F4 with width=0001 -> overflow cleared.
- Assert `reset` at cycle 10 of a frame -> `tx`=1 after the edge; STATUS=0x04; no further transitions.
- With `UART_PARITY_EN`, send 0x07 -> parity bit 1; frame lasts 44 cycles.
